// File: rtl/leds_boost_bar_shifter.sv
`default_nettype none
// ============================================================================
// leds_boost_bar_shifter
//   Expands a lit-LED count into a thermometer bar and shifts it, MSB first,
//   into a daisy-chained 74HC595-style register chain, then latches it.
//   Revision: 1.0
// ============================================================================
module leds_boost_bar_shifter #(
   parameter int NUM_LEDS = 48,
   parameter int CLK_DIV  = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] sel_addr,
   input  logic       enable,
   output logic       sr_data,
   output logic       sr_clk,
   output logic       sr_latch,
   output logic       busy,
   output logic       frame_done
);

   localparam int               DIV_W     = $clog2(CLK_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
   localparam logic [5:0]       LED_MAX   = 6'(NUM_LEDS);
   localparam logic [5:0]       BIT_FIRST = 6'(NUM_LEDS - 1);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_SHIFT_LO = 2'd1;
   localparam logic [1:0] ST_SHIFT_HI = 2'd2;
   localparam logic [1:0] ST_LATCH    = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [5:0]       bit_q, bit_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [5:0]       last_q, last_d;
   logic             dirty_q, dirty_d;
   logic             sr_data_q, sr_data_d;
   logic             sr_clk_q, sr_clk_d;
   logic             sr_latch_q, sr_latch_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;

   logic [5:0]       sel_cnt;
   logic             div_done;
   logic             start;

   // Saturated request, so any sel_addr >= NUM_LEDS maps to the same bar.
   assign sel_cnt  = (sel_addr > LED_MAX) ? LED_MAX : sel_addr;
   assign div_done = (div_q == DIV_LAST);
   // A change seen in the same cycle starts at once, so a frame can follow
   // directly in the frame_done cycle without waiting for dirty to register.
   assign start    = (state_q == ST_IDLE) && enable &&
                     (dirty_q || (sel_cnt != last_q));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         div_q        <= '0;
         bit_q        <= '0;
         cnt_q        <= '0;
         last_q       <= '0;
         dirty_q      <= 1'b1;
         sr_data_q    <= 1'b0;
         sr_clk_q     <= 1'b0;
         sr_latch_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         bit_q        <= bit_d;
         cnt_q        <= cnt_d;
         last_q       <= last_d;
         dirty_q      <= dirty_d;
         sr_data_q    <= sr_data_d;
         sr_clk_q     <= sr_clk_d;
         sr_latch_q   <= sr_latch_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      dirty_d = dirty_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SHIFT_LO;
               div_d   = '0;
               bit_d   = BIT_FIRST;
               cnt_d   = sel_cnt;
               last_d  = sel_cnt;
               dirty_d = 1'b0;
            end else if (sel_cnt != last_q) begin
               dirty_d = 1'b1;
            end
         end
         ST_SHIFT_LO: begin
            if (div_done) begin
               state_d = ST_SHIFT_HI;
               div_d   = '0;
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end
         ST_SHIFT_HI: begin
            if (div_done) begin
               div_d = '0;
               if (bit_q == 6'd0) begin
                  state_d = ST_LATCH;
               end else begin
                  bit_d   = bit_q - 6'd1;
                  state_d = ST_SHIFT_LO;
               end
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end
         ST_LATCH: begin
            if (div_done) begin
               state_d = ST_IDLE;
               div_d   = '0;
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            div_d   = '0;
         end
      endcase
   end

   // Outputs decode the next state so every pin is a flop.
   always_comb begin
      sr_clk_d     = (state_d == ST_SHIFT_HI);
      sr_latch_d   = (state_d == ST_LATCH);
      busy_d       = (state_d != ST_IDLE);
      frame_done_d = (state_q == ST_LATCH) && (state_d == ST_IDLE);
      sr_data_d    = sr_data_q;
      if ((state_d == ST_SHIFT_LO) && (state_q != ST_SHIFT_LO)) begin
         sr_data_d = (bit_d < cnt_d);
      end
   end

   assign sr_data    = sr_data_q;
   assign sr_clk     = sr_clk_q;
   assign sr_latch   = sr_latch_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_leds_boost_bar_shifter.sv
`default_nettype none
// ============================================================================
// tb_leds_boost_bar_shifter
//   Drives two chain configurations and compares whole frames against a
//   count/last-sent model and the frame timing formulas.
// ============================================================================
`timescale 1ns/1ps
module tb_leds_boost_bar_shifter;

   localparam int N_A  = 8;
   localparam int CD_A = 2;
   localparam int N_B  = 48;
   localparam int CD_B = 3;

   logic       clk = 1'b0;
   logic [1:0] rst_n;
   logic [1:0] en;
   logic [5:0] sel [2];
   logic [1:0] sr_data, sr_clk, sr_latch, busy, frame_done;

   int n_checks = 0;
   int n_fail   = 0;
   int m_last  [2];
   bit m_dirty [2];

   always #5 clk = ~clk;

   leds_boost_bar_shifter #(.NUM_LEDS(N_A), .CLK_DIV(CD_A)) u_dut_a (
      .clk        (clk),
      .reset_n    (rst_n[0]),
      .sel_addr   (sel[0]),
      .enable     (en[0]),
      .sr_data    (sr_data[0]),
      .sr_clk     (sr_clk[0]),
      .sr_latch   (sr_latch[0]),
      .busy       (busy[0]),
      .frame_done (frame_done[0])
   );

   leds_boost_bar_shifter #(.NUM_LEDS(N_B), .CLK_DIV(CD_B)) u_dut_b (
      .clk        (clk),
      .reset_n    (rst_n[1]),
      .sel_addr   (sel[1]),
      .enable     (en[1]),
      .sr_data    (sr_data[1]),
      .sr_clk     (sr_clk[1]),
      .sr_latch   (sr_latch[1]),
      .busy       (busy[1]),
      .frame_done (frame_done[1])
   );

   function automatic int n_of(input int w);
      return (w == 1) ? N_B : N_A;
   endfunction

   function automatic int cd_of(input int w);
      return (w == 1) ? CD_B : CD_A;
   endfunction

   function automatic int cnt_of(input logic [5:0] s, input int n);
      return (int'(s) > n) ? n : int'(s);
   endfunction

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called in the cycle where a start is expected; returns in the frame_done cycle.
   task automatic check_frame(input int w, input int cnt, input int mid_c,
                              input logic [5:0] mid_sel, input logic mid_en);
      int n, cd, len, ph;
      int terr, rises, busy_cyc, latch_pulses;
      logic [63:0] got;
      logic prev_clk, prev_latch, prev_data;
      n = n_of(w);
      cd = cd_of(w);
      len = (2 * n + 1) * cd;
      terr = 0; rises = 0; busy_cyc = 0; latch_pulses = 0;
      got = '0;
      prev_clk = 1'b0; prev_latch = 1'b0; prev_data = 1'b0;
      for (int c = 1; c <= len; c++) begin
         step();
         if (c == mid_c) begin
            sel[w] = mid_sel;
            en[w]  = mid_en;
         end
         ph = (c - 1) / cd;
         if (busy[w] === 1'b1) busy_cyc++;
         if (sr_clk[w] !== ((ph < 2 * n) && (ph % 2 == 1))) terr++;
         if (sr_latch[w] !== (ph == 2 * n)) terr++;
         if (frame_done[w] !== 1'b0) terr++;
         // Data may only move when a new low phase begins.
         if ((c > 1) && !((ph < 2 * n) && (ph % 2 == 0) && ((c - 1) % cd == 0)) &&
             (sr_data[w] !== prev_data)) terr++;
         if ((sr_clk[w] === 1'b1) && !prev_clk) begin
            rises++;
            got = {got[62:0], sr_data[w]};
         end
         if ((sr_latch[w] === 1'b1) && !prev_latch) latch_pulses++;
         prev_clk   = sr_clk[w];
         prev_latch = sr_latch[w];
         prev_data  = sr_data[w];
      end
      step();
      check_val("busy_cycles", 64'(busy_cyc), 64'(len));
      check_val("phase_timing_errors", 64'(terr), 64'd0);
      check_val("clk_rises", 64'(rises), 64'(n));
      check_val("latch_pulses", 64'(latch_pulses), 64'd1);
      check_val("bar_bits", got, (64'd1 << cnt) - 64'd1);
      check_val("done_cycle", 64'({frame_done[w], busy[w], sr_clk[w], sr_latch[w]}), 64'b1000);
   endtask

   // One step of the reference: either a whole frame or one idle cycle.
   task automatic advance(input int w, input int mid_c, input logic [5:0] mid_sel, input logic mid_en);
      int c;
      c = cnt_of(sel[w], n_of(w));
      if (en[w] && (m_dirty[w] || (c != m_last[w]))) begin
         m_dirty[w] = 1'b0;
         m_last[w]  = c;
         check_frame(w, c, mid_c, mid_sel, mid_en);
      end else begin
         if (c != m_last[w]) m_dirty[w] = 1'b1;
         step();
         check_val("idle", 64'({frame_done[w], busy[w], sr_clk[w], sr_latch[w]}), 64'd0);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got no completion, expected finish before timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;
      rst_n = 2'b00;
      en    = 2'b00;
      sel[0] = 6'd0;
      sel[1] = 6'd0;
      m_last[0] = 0; m_last[1] = 0;
      m_dirty[0] = 1'b1; m_dirty[1] = 1'b1;

      // Reset state, then one all-zero frame after release.
      en[0] = 1'b1;
      step(); step();
      check_val("reset_outputs", 64'({sr_data[0], sr_clk[0], sr_latch[0], busy[0], frame_done[0]}), 64'd0);
      step();
      rst_n[0] = 1'b1;
      advance(0, 0, sel[0], en[0]);
      for (int i = 0; i < 6; i++) advance(0, 0, sel[0], en[0]);

      // Three-LED bar.
      sel[0] = 6'd3;
      advance(0, 0, sel[0], en[0]);
      advance(0, 0, sel[0], en[0]);

      // Enable gating; dropping enable mid-frame keeps the frame whole.
      en[0] = 1'b0;
      sel[0] = 6'd6;
      for (int i = 0; i < 5; i++) advance(0, 0, sel[0], en[0]);
      en[0] = 1'b1;
      advance(0, 9, sel[0], 1'b0);
      for (int i = 0; i < 4; i++) advance(0, 0, sel[0], en[0]);

      // Asynchronous reset in a high phase, then a full resend.
      en[0] = 1'b1;
      sel[0] = 6'd8;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (sr_clk[0] === 1'b1) found = 1'b1;
      end
      check_val("reach_shift_hi", 64'(found), 64'd1);
      #2 rst_n[0] = 1'b0;
      #1;
      check_val("async_reset", 64'({sr_data[0], sr_clk[0], sr_latch[0], busy[0], frame_done[0]}), 64'd0);
      step(); step();
      rst_n[0] = 1'b1;
      m_dirty[0] = 1'b1;
      m_last[0]  = 0;
      advance(0, 0, sel[0], en[0]);
      advance(0, 0, sel[0], en[0]);

      // Randomized selections, enables and mid-frame disturbances.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) != 0) sel[0] = 6'($urandom_range(0, 12));
         en[0] = ($urandom_range(0, 3) != 0);
         advance(0, int'($urandom_range(0, 40)), 6'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
      end
      en[0] = 1'b0;
      for (int i = 0; i < 3; i++) advance(0, 0, sel[0], en[0]);

      // Long chain: reset frame, saturation, saturated-equal suppression.
      en[1] = 1'b1;
      rst_n[1] = 1'b1;
      advance(1, 0, sel[1], en[1]);
      sel[1] = 6'd63;
      advance(1, 0, sel[1], en[1]);
      sel[1] = 6'd48;
      for (int i = 0; i < 8; i++) advance(1, 0, sel[1], en[1]);

      // Selection change at bit 3 is deferred to a back-to-back frame.
      sel[1] = 6'd5;
      advance(1, 6 * CD_B + 1, 6'd9, 1'b1);
      advance(1, 0, sel[1], en[1]);
      for (int i = 0; i < 4; i++) advance(1, 0, sel[1], en[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
